uart_cmd_decoder: RTL and testbench

Packet decoder that sits directly downstream of the UART byte receiver. It consumes the received byte stream (byte strobe plus the end-of-packet gap pulse) and frames it into tracker command packets: sync byte, address, command code, length, payload and XOR checksum. It buffers the payload and presents each validated, addressed command to the command-execution logic under a valid/ack handshake. It flags checksum, framing and overrun errors.

---
 rtl/uart_cmd_decoder_if.sv | 41 ++++
 rtl/uart_cmd_decoder.sv | 184 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: groups the byte-stream input, the command handshake, the payload read
// port and the status flags of uart_cmd_decoder.
//   rx_valid/rx_data/rx_eop  byte strobe, byte, end-of-packet gap pulse (from UART receiver)
//   cmd_valid/cmd_ack        command held / consumer accepts
//   cmd_addr/cmd_code/cmd_len header fields of the held command
//   buf_idx/buf_data         combinational payload read port
//   err_chk/err_frame/err_ovr one-cycle error pulses; busy = decoder not hunting for sync
// Modports: master = upstream/consumer side driving the decoder, slave = the decoder itself.
interface uart_cmd_decoder_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(MAX_LEN);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_eop;
    logic          cmd_valid;
    logic          cmd_ack;
    logic [7:0]    cmd_addr;
    logic [7:0]    cmd_code;
    logic [LW-1:0] cmd_len;
    logic [IW-1:0] buf_idx;
    logic [7:0]    buf_data;
    logic          err_chk;
    logic          err_frame;
    logic          err_ovr;
    logic          busy;

    modport master (
        output rx_valid, rx_data, rx_eop, cmd_ack, buf_idx,
        input  cmd_valid, cmd_addr, cmd_code, cmd_len, buf_data,
        input  err_chk, err_frame, err_ovr, busy
    );

    modport slave (
        input  rx_valid, rx_data, rx_eop, cmd_ack, buf_idx,
        output cmd_valid, cmd_addr, cmd_code, cmd_len, buf_data,
        output err_chk, err_frame, err_ovr, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: frames the UART byte stream into command packets
//   SYNC ADDR CMD LEN PAYLOAD[LEN] [XOR]
// and holds each validated command addressed to MY_ADDR (or broadcast 8'hFF) under a
// valid/ack handshake. Payload is readable combinationally via buf_idx/buf_data.
// Ports:
//   clk    system clock (UART receiver domain)
//   rst_n  asynchronous active-low reset
//   bus_io uart_cmd_decoder_if.slave (byte stream in, command/handshake/errors out)
// Configuration macro: CMD_CHECKSUM_EN -- when defined the packet ends with an XOR checksum
// byte that is verified; otherwise the packet ends after the payload and err_chk is tied 0.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter logic [7:0]  MY_ADDR   = 8'h05,
    parameter int unsigned MAX_LEN   = 16
) (
    input logic                clk,
    input logic                rst_n,
    uart_cmd_decoder_if.slave  bus_io
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        StHunt, StAddr, StCmd, StLen, StData, StHold
`ifdef CMD_CHECKSUM_EN
        , StChk
`endif
    } state_e;

    state_e        state_q, state_d;
    state_e        done_st;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    code_q, code_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] ptr_inc;
    logic          err_chk_q, err_chk_d;
    logic          err_frame_q, err_frame_d;
    logic          err_ovr_q, err_ovr_d;
    logic          buf_we;
    logic          addr_ok;
    logic [7:0]    buf_q [MAX_LEN];

    assign addr_ok = (addr_q == MY_ADDR) || (addr_q == 8'hFF);
    assign ptr_inc = ptr_q + LW'(1);

    // State entered once the last header/payload byte has been consumed.
    always_comb begin
`ifdef CMD_CHECKSUM_EN
        done_st = StChk;
`else
        done_st = addr_ok ? StHold : StHunt;
`endif
    end

    always_comb begin
        state_d     = state_q;
        xor_d       = xor_q;
        addr_d      = addr_q;
        code_d      = code_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        buf_we      = 1'b0;
        err_chk_d   = 1'b0;
        err_frame_d = 1'b0;
        err_ovr_d   = 1'b0;

        // A gap inside a packet truncates it; rx_eop takes priority over a coincident byte.
        if (bus_io.rx_eop && (state_q != StHunt) && (state_q != StHold)) begin
            err_frame_d = 1'b1;
            state_d     = StHunt;
        end else begin
            case (state_q)
                StHunt: begin
                    if (bus_io.rx_valid && (bus_io.rx_data == SYNC_BYTE)) begin
                        state_d = StAddr;
                        xor_d   = 8'h00;
                    end
                end
                StAddr: begin
                    if (bus_io.rx_valid) begin
                        addr_d  = bus_io.rx_data;
                        xor_d   = xor_q ^ bus_io.rx_data;
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (bus_io.rx_valid) begin
                        code_d  = bus_io.rx_data;
                        xor_d   = xor_q ^ bus_io.rx_data;
                        state_d = StLen;
                    end
                end
                StLen: begin
                    if (bus_io.rx_valid) begin
                        xor_d = xor_q ^ bus_io.rx_data;
                        if (32'(bus_io.rx_data) > MAX_LEN) begin
                            err_frame_d = 1'b1;
                            state_d     = StHunt;
                        end else begin
                            len_d   = bus_io.rx_data[LW-1:0];
                            ptr_d   = '0;
                            state_d = (bus_io.rx_data == 8'h00) ? done_st : StData;
                        end
                    end
                end
                StData: begin
                    if (bus_io.rx_valid) begin
                        buf_we = 1'b1;
                        xor_d  = xor_q ^ bus_io.rx_data;
                        ptr_d  = ptr_inc;
                        if (ptr_inc == len_q) begin
                            state_d = done_st;
                        end
                    end
                end
`ifdef CMD_CHECKSUM_EN
                StChk: begin
                    if (bus_io.rx_valid) begin
                        if (bus_io.rx_data != xor_q) begin
                            err_chk_d = 1'b1;
                            state_d   = StHunt;
                        end else begin
                            state_d = addr_ok ? StHold : StHunt;
                        end
                    end
                end
`endif
                StHold: begin
                    // Bytes are dropped while holding, even in the ack cycle.
                    if (bus_io.rx_valid) begin
                        err_ovr_d = 1'b1;
                    end
                    if (bus_io.cmd_ack) begin
                        state_d = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            xor_q       <= 8'h00;
            addr_q      <= 8'h00;
            code_q      <= 8'h00;
            len_q       <= '0;
            ptr_q       <= '0;
            err_chk_q   <= 1'b0;
            err_frame_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            xor_q       <= xor_d;
            addr_q      <= addr_d;
            code_q      <= code_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            err_chk_q   <= err_chk_d;
            err_frame_q <= err_frame_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[ptr_q[IW-1:0]] <= bus_io.rx_data;
        end
    end

    assign bus_io.cmd_valid = (state_q == StHold);
    assign bus_io.cmd_addr  = addr_q;
    assign bus_io.cmd_code  = code_q;
    assign bus_io.cmd_len   = len_q;
    assign bus_io.buf_data  = (32'(bus_io.buf_idx) < MAX_LEN) ? buf_q[bus_io.buf_idx] : 8'h00;
    assign bus_io.err_chk   = err_chk_q;
    assign bus_io.err_frame = err_frame_q;
    assign bus_io.err_ovr   = err_ovr_q;
    assign bus_io.busy      = (state_q != StHunt);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed testbench for uart_cmd_decoder; works with or without CMD_CHECKSUM_EN.
module tb_uart_cmd_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_cmd_decoder_if #(.MAX_LEN(16)) bus ();

    uart_cmd_decoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Drive one byte for one cycle; returns 1 time unit after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eop();
        bus.rx_eop = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_eop = 1'b0;
    endtask

    task automatic do_ack();
        bus.cmd_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ack = 1'b0;
    endtask

    // Full packet with up to two payload bytes; checksum appended when enabled.
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] c, input logic [7:0] l,
                            input logic [7:0] p0, input logic [7:0] p1);
`ifdef CMD_CHECKSUM_EN
        logic [7:0] chk;
        chk = a ^ c ^ l;
        if (l > 0) chk = chk ^ p0;
        if (l > 1) chk = chk ^ p1;
`endif
        send_byte(8'hAA);
        send_byte(a);
        send_byte(c);
        send_byte(l);
        if (l > 0) send_byte(p0);
        if (l > 1) send_byte(p1);
`ifdef CMD_CHECKSUM_EN
        send_byte(chk);
`endif
    endtask

    task automatic test_reset();
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++;
            $display("FAIL reset_cmd_valid got=%0h exp=0", bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 8'h00) begin errors++;
            $display("FAIL reset_cmd_addr got=%0h exp=0", bus.cmd_addr); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++;
            $display("FAIL reset_cmd_code got=%0h exp=0", bus.cmd_code); end
        checks++; if (bus.cmd_len !== 5'd0) begin errors++;
            $display("FAIL reset_cmd_len got=%0h exp=0", bus.cmd_len); end
        checks++; if ({bus.err_chk, bus.err_frame, bus.err_ovr, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus.err_chk, bus.err_frame, bus.err_ovr, bus.busy});
        end
    endtask

    task automatic test_good_packet();
        send_byte(8'hAA);
        checks++; if (bus.busy !== 1'b1) begin errors++;
            $display("FAIL good_busy_after_sync got=%0h exp=1", bus.busy); end
        send_byte(8'h05);
        send_byte(8'h12);
        send_byte(8'h02);
        send_byte(8'h34);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h56);
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++;
            $display("FAIL good_valid_early got=%0h exp=0", bus.cmd_valid); end
        send_byte(8'h77);
`else
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++;
            $display("FAIL good_valid_early got=%0h exp=0", bus.cmd_valid); end
        send_byte(8'h56);
`endif
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++;
            $display("FAIL good_cmd_valid got=%0h exp=1", bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 8'h05) begin errors++;
            $display("FAIL good_cmd_addr got=%0h exp=05", bus.cmd_addr); end
        checks++; if (bus.cmd_code !== 8'h12) begin errors++;
            $display("FAIL good_cmd_code got=%0h exp=12", bus.cmd_code); end
        checks++; if (bus.cmd_len !== 5'd2) begin errors++;
            $display("FAIL good_cmd_len got=%0h exp=2", bus.cmd_len); end
        bus.buf_idx = 4'd0; #1;
        checks++; if (bus.buf_data !== 8'h34) begin errors++;
            $display("FAIL good_buf0 got=%0h exp=34", bus.buf_data); end
        bus.buf_idx = 4'd1; #1;
        checks++; if (bus.buf_data !== 8'h56) begin errors++;
            $display("FAIL good_buf1 got=%0h exp=56", bus.buf_data); end
        idle_cycle();
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++;
            $display("FAIL good_valid_held got=%0h exp=1", bus.cmd_valid); end
        do_ack();
        checks++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL good_after_ack got valid=%0h busy=%0h exp 0/0",
                     bus.cmd_valid, bus.busy); end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_bad_checksum();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h12);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h76);
        checks++; if (bus.err_chk !== 1'b1) begin errors++;
            $display("FAIL badchk_pulse got=%0h exp=1", bus.err_chk); end
        checks++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL badchk_state got valid=%0h busy=%0h exp 0/0",
                     bus.cmd_valid, bus.busy); end
        idle_cycle();
        checks++; if (bus.err_chk !== 1'b0) begin errors++;
            $display("FAIL badchk_single got=%0h exp=0", bus.err_chk); end
    endtask
`endif

    task automatic test_addr_filter();
        send_pkt(8'h07, 8'h12, 8'h00, 8'h00, 8'h00);
        checks++; if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL foreign_state got valid=%0h busy=%0h exp 0/0",
                     bus.cmd_valid, bus.busy); end
        checks++; if ({bus.err_chk, bus.err_frame, bus.err_ovr} !== 3'b000) begin errors++;
            $display("FAIL foreign_errors got=%b exp=000",
                     {bus.err_chk, bus.err_frame, bus.err_ovr}); end
        send_pkt(8'hFF, 8'h12, 8'h00, 8'h00, 8'h00);
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++;
            $display("FAIL bcast_valid got=%0h exp=1", bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 8'hFF || bus.cmd_len !== 5'd0) begin errors++;
            $display("FAIL bcast_fields got addr=%0h len=%0h exp FF/0",
                     bus.cmd_addr, bus.cmd_len); end
        do_ack();
    endtask

    task automatic test_framing();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h12);
        send_byte(8'h04);
        send_byte(8'h01);
        pulse_eop();
        checks++; if (bus.err_frame !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL trunc got frame=%0h busy=%0h exp 1/0", bus.err_frame, bus.busy); end
        idle_cycle();
        checks++; if (bus.err_frame !== 1'b0) begin errors++;
            $display("FAIL trunc_single got=%0h exp=0", bus.err_frame); end
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h12);
        send_byte(8'h11);
        checks++; if (bus.err_frame !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL oversize got frame=%0h busy=%0h exp 1/0", bus.err_frame, bus.busy); end
        idle_cycle();
        checks++; if (bus.cmd_valid !== 1'b0 || bus.err_frame !== 1'b0) begin errors++;
            $display("FAIL oversize_after got valid=%0h frame=%0h exp 0/0",
                     bus.cmd_valid, bus.err_frame); end
    endtask

    task automatic test_overrun();
        send_pkt(8'h05, 8'h33, 8'h02, 8'hA1, 8'hB2);
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++;
            $display("FAIL ovr_hold got=%0h exp=1", bus.cmd_valid); end
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hAA);
            checks++; if (bus.err_ovr !== 1'b1) begin errors++;
                $display("FAIL ovr_pulse%0d got=%0h exp=1", i, bus.err_ovr); end
        end
        idle_cycle();
        checks++; if (bus.err_ovr !== 1'b0) begin errors++;
            $display("FAIL ovr_clear got=%0h exp=0", bus.err_ovr); end
        pulse_eop();
        checks++; if (bus.err_frame !== 1'b0 || bus.cmd_valid !== 1'b1) begin errors++;
            $display("FAIL hold_eop got frame=%0h valid=%0h exp 0/1",
                     bus.err_frame, bus.cmd_valid); end
        checks++; if (bus.cmd_code !== 8'h33 || bus.cmd_len !== 5'd2) begin errors++;
            $display("FAIL ovr_fields got code=%0h len=%0h exp 33/2", bus.cmd_code, bus.cmd_len); end
        bus.buf_idx = 4'd0; #1;
        checks++; if (bus.buf_data !== 8'hA1) begin errors++;
            $display("FAIL ovr_buf0 got=%0h exp=A1", bus.buf_data); end
        bus.buf_idx = 4'd1; #1;
        checks++; if (bus.buf_data !== 8'hB2) begin errors++;
            $display("FAIL ovr_buf1 got=%0h exp=B2", bus.buf_data); end
        // Ack with a byte in the same cycle: still an overrun.
        bus.cmd_ack  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        @(posedge clk);
        #1;
        bus.cmd_ack  = 1'b0;
        bus.rx_valid = 1'b0;
        checks++; if (bus.err_ovr !== 1'b1 || bus.cmd_valid !== 1'b0) begin errors++;
            $display("FAIL ack_ovr got ovr=%0h valid=%0h exp 1/0", bus.err_ovr, bus.cmd_valid); end
        send_pkt(8'h05, 8'h44, 8'h01, 8'h9C, 8'h00);
        bus.buf_idx = 4'd0; #1;
        checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h44 ||
                      bus.buf_data !== 8'h9C) begin errors++;
            $display("FAIL post_ovr_pkt got valid=%0h code=%0h buf0=%0h exp 1/44/9C",
                     bus.cmd_valid, bus.cmd_code, bus.buf_data); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h12);
        send_byte(8'h02);
        send_byte(8'h34);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_state got busy=%0h valid=%0h exp 0/0", bus.busy, bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 8'h00 || bus.cmd_code !== 8'h00 ||
                      bus.cmd_len !== 5'd0) begin errors++;
            $display("FAIL rstmid_fields got addr=%0h code=%0h len=%0h exp 0/0/0",
                     bus.cmd_addr, bus.cmd_code, bus.cmd_len); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        send_pkt(8'h05, 8'h66, 8'h02, 8'h01, 8'h02);
        bus.buf_idx = 4'd1; #1;
        checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h66 ||
                      bus.cmd_len !== 5'd2 || bus.buf_data !== 8'h02) begin errors++;
            $display("FAIL rstmid_fresh got valid=%0h code=%0h len=%0h buf1=%0h exp 1/66/2/02",
                     bus.cmd_valid, bus.cmd_code, bus.cmd_len, bus.buf_data); end
        do_ack();
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_eop   = 1'b0;
        bus.cmd_ack  = 1'b0;
        bus.buf_idx  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        idle_cycle();
        test_good_packet();
`ifdef CMD_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_addr_filter();
        test_framing();
        test_overrun();
        test_reset_mid();
        checks++; if (bus.err_chk !== 1'b0) begin errors++;
            $display("FAIL final_err_chk got=%0h exp=0", bus.err_chk); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
